// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants, baud divider.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_MID_SAMPLE = 7;
  localparam int UART_DATA_BITS  = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_rx_state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;
`endif

  // Clocks per oversample tick, rounded to nearest, never below 1.
  function automatic int uart_div(input int clk_hz, input int baud);
    int d;
    d = (clk_hz + baud * (UART_OVERSAMPLE / 2)) / (baud * UART_OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// Free-running DIV counter emitting o_tick on its last count; clear re-phases it.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic o_tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign o_tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk)
    if (rst || clear || o_tick) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_rx_core.sv
// 16x oversampling UART receiver with valid/ready byte output.
// Default frame 8N1; define UART_RX_PARITY_EN for 8E1 with o_parity_err.
module uart_rx_core import uart_pkg::*; #(
  parameter int CLK_HZ = 64_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err
);
  localparam int DIV = uart_div(CLK_HZ, BAUD);
  localparam logic [3:0] S_MID  = 4'(UART_MID_SAMPLE);
  localparam logic [3:0] S_LAST = 4'(UART_OVERSAMPLE - 1);
  localparam logic [2:0] B_LAST = 3'(UART_DATA_BITS - 1);

  logic rx_m, rx_s, rx_d, fall;
  uart_rx_state_t state, state_n;
  logic [3:0] scnt;
  logic [2:0] bitcnt;
  logic [UART_DATA_BITS-1:0] shreg;
  logic tick, tick_clr, at_sample, byte_done, frame_bad, hs, par_bad;

  // rx_d is the edge register; start detect is rx_s falling.
  always_ff @(posedge clk)
    if (rst) {rx_m, rx_s, rx_d} <= 3'b111;
    else begin
      rx_m <= i_uart_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end

  assign fall = rx_d & ~rx_s;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clr),
    .o_tick(tick)
  );

  always_comb begin
    state_n   = state;
    tick_clr  = 1'b0;
    at_sample = 1'b0;
    case (state)
      IDLE: if (fall) begin
        state_n  = START;
        tick_clr = 1'b1;
      end
      START: begin
        at_sample = tick && (scnt == S_MID);
        if (at_sample) state_n = rx_s ? IDLE : DATA;
      end
      DATA: begin
        at_sample = tick && (scnt == S_LAST);
        if (at_sample && bitcnt == B_LAST)
`ifdef UART_RX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        at_sample = tick && (scnt == S_LAST);
        if (at_sample) state_n = STOP;
      end
`endif
      STOP: begin
        at_sample = tick && (scnt == S_LAST);
        if (at_sample) state_n = rx_s ? IDLE : BREAK;
      end
      BREAK: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign byte_done = (state == STOP) && at_sample && rx_s && !par_bad;
  assign frame_bad = (state == STOP) && at_sample && !rx_s;
  assign hs        = o_valid & i_ready;
  assign o_busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      scnt        <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state       <= state_n;
      o_frame_err <= frame_bad;
      if (tick_clr) begin
        scnt   <= '0;
        bitcnt <= '0;
      end else if (tick) begin
        scnt <= at_sample ? '0 : scnt + 1'b1;
      end
      if (state == DATA && at_sample) begin
        shreg  <= {rx_s, shreg[UART_DATA_BITS-1:1]};
        bitcnt <= bitcnt + 1'b1;
      end
      // A handshake in the same cycle frees the register for the new byte.
      if (byte_done && (!o_valid || hs)) begin
        o_data  <= shreg;
        o_valid <= 1'b1;
      end else if (hs) begin
        o_valid <= 1'b0;
      end
      if (hs)                        o_overrun <= 1'b0;
      else if (byte_done && o_valid) o_overrun <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_mis;
  assign par_mis = (state == PARITY) && at_sample && ((^shreg) ^ rx_s);

  always_ff @(posedge clk)
    if (rst) begin
      par_bad      <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      o_parity_err <= par_mis;
      if (tick_clr)     par_bad <= 1'b0;
      else if (par_mis) par_bad <= 1'b1;
    end
`else
  assign par_bad      = 1'b0;
  assign o_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at DIV=1 (16 clk per bit), random and directed frames.
module tb_uart_rx_core;
  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int BITC   = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = (10 * 16 + 8) + 3;
`else
  localparam int LAT = (9 * 16 + 8) + 3;
`endif

  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid, o_busy, o_frame_err, o_overrun, o_parity_err;

  int total = 0, bad = 0;
  int cyc = 0, vrise = 0, fe_cyc = 0, pe_cyc = 0, rise_cyc = 0;
  logic v_q = 1'b0;
  logic [7:0] rxq[$];

  uart_rx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_uart_rx   (rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_parity_err(o_parity_err)
  );

  always #5 clk = ~clk;

  // Observer: sees the same pre-edge values the DUT acts on.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    v_q <= o_valid;
    if (!rst) begin
      if (o_valid && i_ready) rxq.push_back(o_data);
      if (o_valid && !v_q) begin
        vrise    <= vrise + 1;
        rise_cyc <= cyc;
      end
      if (o_frame_err)  fe_cyc <= fe_cyc + 1;
      if (o_parity_err) pe_cyc <= pe_cyc + 1;
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BITC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_b);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({o_data, o_valid, o_busy, o_frame_err, o_overrun, o_parity_err} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%0h want=0",
               {o_data, o_valid, o_busy, o_frame_err, o_overrun, o_parity_err});
    end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_single;
    int base, vr0, fe0, t0, lat;
    i_ready = 1'b1;
    base = rxq.size(); vr0 = vrise; fe0 = fe_cyc; t0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(10);
    total++;
    if (rxq.size() != base + 1 || rxq[rxq.size()-1] !== 8'hA5) begin
      bad++;
      $display("FAIL single_data got_n=%0d want_n=%0d", rxq.size() - base, 1);
    end
    total++;
    if (vrise - vr0 != 1) begin
      bad++;
      $display("FAIL single_valid_pulses got=%0d want=1", vrise - vr0);
    end
    total++;
    if (fe_cyc != fe0 || o_overrun !== 1'b0 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_flags got_fe=%0d ovr=%b valid=%b want=0", fe_cyc - fe0, o_overrun, o_valid);
    end
    lat = rise_cyc - t0;
    total++;
    if (lat < LAT - 1 || lat > LAT + 1) begin
      bad++;
      $display("FAIL single_latency got=%0d want=%0d", lat, LAT);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    i_ready = 1'b0;
    base = rxq.size();
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(4);
    total++;
    if (o_data !== 8'h3C || o_valid !== 1'b1) begin
      bad++;
      $display("FAIL overrun_hold got=%0h/%b want=3c/1", o_data, o_valid);
    end
    total++;
    if (o_overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_flag got=%b want=1", o_overrun);
    end
    i_ready = 1'b1;
    @(negedge clk);
    total++;
    if (o_overrun !== 1'b0 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear got=%b/%b want=0/0", o_overrun, o_valid);
    end
    total++;
    if (rxq.size() != base + 1 || rxq[rxq.size()-1] !== 8'h3C) begin
      bad++;
      $display("FAIL overrun_handshake got_n=%0d want_n=1", rxq.size() - base);
    end
    idle(5);
  endtask

  task automatic test_glitch;
    int vr0, n;
    vr0 = vrise; n = 0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (o_busy !== 1'b1) begin
      bad++;
      $display("FAIL glitch_busy_rise got=%b want=1", o_busy);
    end
    rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!o_busy) break;
      @(negedge clk);
      n++;
    end
    total++;
    if (o_busy !== 1'b0 || n > 9) begin
      bad++;
      $display("FAIL glitch_busy_drop got=%0d clk want<=9", n);
    end
    idle(20);
    total++;
    if (vrise != vr0) begin
      bad++;
      $display("FAIL glitch_no_valid got=%0d want=0", vrise - vr0);
    end
  endtask

  task automatic test_frame_err;
    int base, vr0, fe0;
    base = rxq.size(); vr0 = vrise; fe0 = fe_cyc;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (fe_cyc - fe0 != 1 || vrise != vr0) begin
      bad++;
      $display("FAIL frame_err_pulse got_fe=%0d got_v=%0d want=1/0", fe_cyc - fe0, vrise - vr0);
    end
    idle(20);
    send_frame(8'h12, 1'b1);
    idle(10);
    total++;
    if (rxq.size() != base + 1 || rxq[rxq.size()-1] !== 8'h12) begin
      bad++;
      $display("FAIL frame_err_recover got_n=%0d want_n=1", rxq.size() - base);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    int base, fe0;
    d = 8'h5A; base = rxq.size(); fe0 = fe_cyc;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (8) @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    total++;
    if ({o_data, o_valid, o_busy, o_frame_err, o_overrun, o_parity_err} !== 13'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs got=%0h want=0",
               {o_data, o_valid, o_busy, o_frame_err, o_overrun, o_parity_err});
    end
    rst = 1'b0;
    idle(20);
    send_frame(8'h7E, 1'b1);
    idle(10);
    total++;
    if (rxq.size() != base + 1 || rxq[rxq.size()-1] !== 8'h7E || fe_cyc != fe0) begin
      bad++;
      $display("FAIL reset_mid_recover got_n=%0d fe=%0d want=1/0", rxq.size() - base, fe_cyc - fe0);
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int base;
    i_ready = 1'b1;
    base = rxq.size();
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      send_frame(d, 1'b1);
      idle($urandom_range(0, 20));
    end
    idle(20);
    total++;
    if (rxq.size() - base != exp_q.size()) begin
      bad++;
      $display("FAIL random_count got=%0d want=%0d", rxq.size() - base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        total++;
        if (rxq[base+k] !== exp_q[k]) begin
          bad++;
          $display("FAIL random_byte%0d got=%0h want=%0h", k, rxq[base+k], exp_q[k]);
        end
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic p);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(1'b1);
  endtask

  task automatic test_parity;
    int base, vr0, pe0;
    i_ready = 1'b1;
    base = rxq.size(); vr0 = vrise; pe0 = pe_cyc;
    send_frame_par(8'h01, 1'b0);
    idle(10);
    total++;
    if (pe_cyc - pe0 != 1 || vrise != vr0) begin
      bad++;
      $display("FAIL parity_bad got_pe=%0d got_v=%0d want=1/0", pe_cyc - pe0, vrise - vr0);
    end
    send_frame_par(8'h01, 1'b1);
    idle(10);
    total++;
    if (rxq.size() != base + 1 || rxq[rxq.size()-1] !== 8'h01 || pe_cyc - pe0 != 1) begin
      bad++;
      $display("FAIL parity_good got_n=%0d want_n=1", rxq.size() - base);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_reset_mid;
    test_random;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
